// File: rtl/mod_100_if.sv
//------------------------------------------------------------------------------
// Module      : mod_100_if
// Description : Control and timing bundle for the modulo-DIVISOR counter /
//               clock divider.
//               BCD digits are present only when MOD_100_BCD_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mod_100_if #(
    parameter int CW = 7
);
    logic          en;
    logic          clk_mod;
    logic          tick;
    logic [CW-1:0] count;
`ifdef MOD_100_BCD_EN
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_units;

    modport master (output en, input clk_mod, input tick, input count,
                    input bcd_tens, input bcd_units);
    modport slave  (input en, output clk_mod, output tick, output count,
                    output bcd_tens, output bcd_units);
`else
    modport master (output en, input clk_mod, input tick, input count);
    modport slave  (input en, output clk_mod, output tick, output count);
`endif
endinterface

`default_nettype wire

// File: rtl/mod_100.sv
//------------------------------------------------------------------------------
// Module      : mod_100
// Description : Free-running modulo-DIVISOR counter with 50% divided clock,
//               wrap tick and optional BCD digits (macro MOD_100_BCD_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_100 #(
    parameter int DIVISOR = 100,
    parameter int CW      = $clog2(DIVISOR)
) (
    input  wire logic clk,
    input  wire logic rst,
    mod_100_if.slave  bus
);

    localparam logic [CW-1:0] c_LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] c_HALF = CW'(DIVISOR / 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          clk_mod_q;
    logic          tick_q;
    logic          wrap;

    always_comb begin
        wrap    = (count_q == c_LAST);
        count_d = wrap ? '0 : count_q + CW'(1);
    end

    // Disabled cycles freeze everything except tick, which drops so a wrap
    // pulse is never stretched by a pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            clk_mod_q <= 1'b0;
            tick_q    <= 1'b0;
        end else if (bus.en) begin
            count_q   <= count_d;
            clk_mod_q <= (count_d >= c_HALF);
            tick_q    <= wrap;
        end else begin
            tick_q    <= 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.clk_mod = clk_mod_q;
    assign bus.tick    = tick_q;

`ifdef MOD_100_BCD_EN
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] units_q;
    logic [3:0] units_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q + 4'd1;
        if (wrap) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else if (bus.en) begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_units = units_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_100.sv
//------------------------------------------------------------------------------
// Module      : tb_mod_100
// Description : Scoreboard bench for mod_100 (DIVISOR=100 and DIVISOR=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_100;

    logic clk;
    logic rst;

    mod_100_if #(.CW(7)) if1 ();
    mod_100_if #(.CW(1)) if2 ();

    mod_100 #(.DIVISOR(100), .CW(7)) u_dut (.clk(clk), .rst(rst), .bus(if1.slave));
    mod_100 #(.DIVISOR(2),   .CW(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        int cnt1;
        bit clk1;
        bit tk1;
        int cnt2;
        bit clk2;
        bit tk2;
        int tens;
        int units;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_en  = 0;
    int   n_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected values come from the enabled-edge count since reset:
    // count = n mod D, clk_mod = (n mod D) >= D/2, tick on enabled edges
    // where n is a nonzero multiple of D.
    task automatic step(input logic r, input logic e);
        exp_t x;
        bit   tk;
        @(negedge clk);
        rst    = r;
        if1.en = e;
        if2.en = e;
        tk     = 1'b0;
        if (r) begin
            n_en = 0;
        end else if (e) begin
            n_en++;
            tk = 1'b1;
        end
        x.cnt1  = n_en % 100;
        x.clk1  = (x.cnt1 >= 50);
        x.tk1   = tk && (x.cnt1 == 0);
        x.cnt2  = n_en % 2;
        x.clk2  = (x.cnt2 == 1);
        x.tk2   = tk && (x.cnt2 == 0);
        x.tens  = x.cnt1 / 10;
        x.units = x.cnt1 % 10;
        q.push_back(x);
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cyc++;
                n_cmp++;
                if ({if1.count, if1.clk_mod, if1.tick} !== {7'(e.cnt1), e.clk1, e.tk1}) begin
                    n_bad++;
                    $display("FAIL div100 cyc=%0d: got count=%0d clk_mod=%b tick=%b, want count=%0d clk_mod=%b tick=%b",
                             n_cyc, if1.count, if1.clk_mod, if1.tick, e.cnt1, e.clk1, e.tk1);
                end
                n_cmp++;
                if ({if2.count, if2.clk_mod, if2.tick} !== {1'(e.cnt2), e.clk2, e.tk2}) begin
                    n_bad++;
                    $display("FAIL div2 cyc=%0d: got count=%0d clk_mod=%b tick=%b, want count=%0d clk_mod=%b tick=%b",
                             n_cyc, if2.count, if2.clk_mod, if2.tick, e.cnt2, e.clk2, e.tk2);
                end
`ifdef MOD_100_BCD_EN
                n_cmp++;
                if ({if1.bcd_tens, if1.bcd_units} !== {4'(e.tens), 4'(e.units)}) begin
                    n_bad++;
                    $display("FAIL bcd cyc=%0d: got tens=%0d units=%0d, want tens=%0d units=%0d",
                             n_cyc, if1.bcd_tens, if1.bcd_units, e.tens, e.units);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        rst    = 1'b1;
        if1.en = 1'b0;
        if2.en = 1'b0;

        // Reset for two cycles with en high, then 250 enabled cycles.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run(250, 1'b1);

        // Advance to count=30, pause 17 cycles, resume through the next wrap.
        run(80, 1'b1);
        run(17, 1'b0);
        run(75, 1'b1);

        // Reach count=75 (clk_mod high), reset mid-period, then a full period.
        run(70, 1'b1);
        step(1'b1, 1'b1);
        run(105, 1'b1);

        // Irregular enable pattern across a wrap.
        for (int i = 0; i < 120; i++) step(1'b0, (i % 3) != 0);

        @(negedge clk);
        if1.en = 1'b0;
        if2.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
